keccak_digest_reader: RTL and testbench
=======================================

Name: keccak_digest_reader

Overview:
Consumer side of the keccak core's output interface. It watches out_ready and captures the 512-bit out digest on its rising edge. It then streams the digest as 32-bit words over a valid/ready handshake to a downstream sink such as a bus slave, UART bridge or checker. It sits directly after keccak and completes the path opposite to the message-feeding side.

Parameters:
DIGEST_W, 512, width of the digest bus from keccak.
WORD_W, 32, width of each emitted word; DIGEST_W must be a multiple of WORD_W.
NUM_WORDS, 16, number of words emitted per digest, from the MSB end; must be ≤ DIGEST_W/WORD_W (e.g. 8 gives a 256-bit truncated digest).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset.
out  input  DIGEST_W  digest from keccak; valid while out_ready=1.
out_ready  input  1  keccak digest-valid level.
dout  output  WORD_W  current digest word.
dout_valid  output  1  dout holds a valid word.
dout_ready  input  1  sink accepts the word.
dout_last  output  1  asserted with the final word (index NUM_WORDS-1).
busy  output  1  a digest is captured and not yet fully sent.
overrun  output  1  sticky; a new digest arrived while busy.

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE; dout=0, dout_valid=0, dout_last=0, busy=0, overrun=0, word index=0, out_ready history register=0.
- Edge detect: rise = out_ready & ~out_ready_q. out_ready_q is updated every cycle. A level held high never retriggers.
- State IDLE: on rise, capture out into the shadow register, set index=0, busy=1 and go to SEND. The capture happens in the same edge on which rise is seen, so dout_valid is asserted in the next cycle (latency 1).
- State SEND:
  - dout = shadow[DIGEST_W-1-WORD_W*idx -: WORD_W]; word 0 is out[511:480].
  - dout_valid=1. dout_last=1 iff idx==NUM_WORDS-1.
  - A transfer occurs on a clk edge with dout_valid & dout_ready.
  - On transfer with idx<NUM_WORDS-1: idx increments.
  - On transfer of the last word: go to IDLE with dout_valid=0 and busy=0 in the following cycle.
  - dout and dout_last hold stable while dout_valid=1 and dout_ready=0.
- Back-to-back words: with dout_ready held high, one word per cycle. A full digest takes NUM_WORDS cycles after the first valid.
- out_ready falling mid-SEND (keccak reset for the next message): no effect. The shadow copy continues to drain.
- rise while in SEND: the new digest is dropped and overrun is set to 1. overrun stays 1 until reset. The current stream continues unchanged.
- rise on the same edge as the last-word transfer: treated as IDLE-entry. The new digest is captured and SEND restarts at idx=0 with no gap cycle; overrun is not set.
- Reset mid-SEND: returns immediately to the reset values; the partial stream is abandoned and no dout_last is emitted.
- The out input is sampled only at capture; changes at other times are ignored.

Optional Feature:
KECCAK_READER_BSWAP_EN
- Defined: each emitted word is byte-reversed (dout[7:0] = word[31:24], etc.), giving little-endian byte order for byte-addressed sinks. This applies only when WORD_W=32.
- Undefined: words are emitted unmodified, big-endian as on out.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package keccak_pkg holds:
  - DIGEST_W_DEFAULT=512 and WORD_W_DEFAULT=32.
  - The state enum {IDLE, SEND}.
  - A function bswap32.
- One natural sub-module: keccak_rise_detect (1-bit registered edge detector with the same clk/reset), reusable by other out_ready consumers.
- The remaining datapath (shadow register, word mux, index counter) stays in the top module.

Test Plan:
- Basic read: raise out_ready with out = 512'h0123…(incrementing bytes 00..3F), dout_ready=1. Expect dout_valid one cycle later. Expect 16 consecutive words 32'h00010203 … 32'h3C3D3E3F. dout_last=1 only on the 16th; busy then drops.
- Backpressure: dout_ready toggled 1,0,0,1,… Expect dout stable while stalled and no skipped or duplicated words. Expect exactly 16 transfers.
- Overrun: second rise (out_ready 1→0→1) at word 5. Expect overrun=1 sticky and the remaining words from the first digest. Then apply reset=0 for one cycle; expect overrun=0 and dout_valid=0.
- Truncation: NUM_WORDS=8. Expect only out[511:256] emitted, with dout_last on word 8.
- Boundary: rise coincident with the last-word transfer. Expect the first word of the new digest valid on the next cycle with overrun=0.
- BSWAP build: word 0 of the incrementing pattern is 32'h03020100. Without the macro it is 32'h00010203.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared types and helpers for the keccak digest consumers.
package keccak_pkg;
  localparam int DIGEST_W_DEFAULT = 512;
  localparam int WORD_W_DEFAULT   = 32;

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/keccak_rise_detect.sv
// Registered rising-edge detector for a keccak digest-valid level.
module keccak_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk) begin
    if (!reset) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/keccak_digest_reader.sv
// Captures the keccak digest on out_ready rise and streams it MSB-first as
// WORD_W words over valid/ready. Define KECCAK_READER_BSWAP_EN for byte-reversed words.
module keccak_digest_reader
  import keccak_pkg::*;
#(
  parameter int DIGEST_W  = DIGEST_W_DEFAULT,
  parameter int WORD_W    = WORD_W_DEFAULT,
  parameter int NUM_WORDS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIGEST_W-1:0] out,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last,
  output logic                busy,
  output logic                overrun
);
  localparam int KEEP_W = NUM_WORDS * WORD_W;
  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t                           state_q, state_d;
  logic [KEEP_W-1:0]                shadow_q;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             overrun_q;
  logic                             rise, is_last, xfer, capture, drop;
  logic [NUM_WORDS-1:0][WORD_W-1:0] words;
  logic [WORD_W-1:0]                word_sel, word_out;

  keccak_rise_detect u_rise (
    .clk  (clk),
    .reset(reset),
    .d    (out_ready),
    .rise (rise)
  );

  assign is_last = (idx_q == LAST_IDX);
  assign xfer    = (state_q == SEND) && dout_ready;
  // A rise that lands on the final transfer starts the next digest with no gap.
  assign capture = rise && ((state_q == IDLE) || (xfer && is_last));
  assign drop    = rise && !capture;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (capture) begin
      state_d = SEND;
      idx_d   = '0;
    end else if (xfer) begin
      if (is_last) state_d = IDLE;
      else         idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (drop) overrun_q <= 1'b1;
    end
  end

  // Only the words that will be emitted are kept.
  always_ff @(posedge clk) begin
    if (reset && capture) shadow_q <= out[DIGEST_W-1 -: KEEP_W];
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
    assign words[g] = shadow_q[KEEP_W-1-WORD_W*g -: WORD_W];
  end

  assign word_sel = words[idx_q];

`ifdef KECCAK_READER_BSWAP_EN
  if (WORD_W == 32) begin : g_bswap
    assign word_out = bswap32(word_sel);
  end else begin : g_nobswap
    assign word_out = word_sel;
  end
`else
  assign word_out = word_sel;
`endif

  assign dout_valid = (state_q == SEND);
  assign dout       = dout_valid ? word_out : '0;
  assign dout_last  = dout_valid && is_last;
  assign busy       = dout_valid;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_keccak_digest_reader.sv
// Self-checking bench for keccak_digest_reader: scoreboard of expected words,
// table-driven streaming vectors plus overrun, reset, boundary and truncation sequences.
module tb_keccak_digest_reader;
  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] out;
  logic         out_ready;
  logic [31:0]  dout, dout8;
  logic         dout_valid, dout_last, busy, overrun;
  logic         dout_valid8, dout_last8, busy8, overrun8;
  logic         dout_ready, dout_ready8;

  always #5 clk = ~clk;

  keccak_digest_reader dut (
    .clk(clk), .reset(reset), .out(out), .out_ready(out_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .overrun(overrun)
  );

  keccak_digest_reader #(.NUM_WORDS(8)) dut8 (
    .clk(clk), .reset(reset), .out(out), .out_ready(out_ready),
    .dout(dout8), .dout_valid(dout_valid8), .dout_ready(dout_ready8),
    .dout_last(dout_last8), .busy(busy8), .overrun(overrun8)
  );

  typedef struct packed {logic [31:0] w; logic last;} exp_t;
  typedef struct {
    logic [511:0] digest;
    logic [3:0]   rdy;      // dout_ready pattern, bit (cycle % 4)
    logic [31:0]  exp_w0;
    int           exp_xfers;
  } vec_t;

  exp_t  sb[$];
  exp_t  sb8[$];
  vec_t  vecs[3];
  int    checks = 0, failures = 0;
  int    xfers = 0, xfers8 = 0;
  logic  held_valid = 1'b0;
  logic [31:0] held_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [511:0] d, input int i);
    logic [31:0] w;
    w = d[511-32*i -: 32];
`ifdef KECCAK_READER_BSWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  task automatic push(input logic [511:0] d, input int n, input bit to8);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.w = exp_word(d, i);
      e.last = (i == n - 1);
      if (to8) sb8.push_back(e); else sb.push_back(e);
    end
  endtask

  // Called at a negedge with inputs set: checks the handshake the next posedge will see.
  task automatic step();
    exp_t e;
    #1;
    if (dout_valid) begin
      if (held_valid) chk("stall_hold", dout, held_dout);
      if (dout_ready) begin
        if (sb.size() == 0) chk("unexpected_word", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("word", dout, e.w);
          chk("last", {31'd0, dout_last}, {31'd0, e.last});
        end
        xfers++;
        held_valid = 1'b0;
      end else begin
        held_valid = 1'b1;
        held_dout  = dout;
      end
    end else held_valid = 1'b0;
    if (dout_valid8 && dout_ready8) begin
      if (sb8.size() == 0) chk("unexpected_word8", 32'd1, 32'd0);
      else begin
        e = sb8.pop_front();
        chk("word8", dout8, e.w);
        chk("last8", {31'd0, dout_last8}, {31'd0, e.last});
      end
      xfers8++;
    end
    @(negedge clk);
  endtask

  task automatic drain(input logic [3:0] pat, input int maxc);
    int c = 0;
    while ((sb.size() > 0 || sb8.size() > 0) && c < maxc) begin
      dout_ready = pat[c % 4];
      step();
      c++;
    end
    if (sb.size() > 0 || sb8.size() > 0) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [511:0] rand_digest();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    logic [511:0] inc, d1, d2;
    int x0;
    for (int k = 0; k < 64; k++) inc[511-8*k -: 8] = 8'(k);

`ifdef KECCAK_READER_BSWAP_EN
    vecs[0] = '{inc, 4'b1111, 32'h03020100, 16};
`else
    vecs[0] = '{inc, 4'b1111, 32'h00010203, 16};
`endif
    d1 = rand_digest();
    vecs[1] = '{d1, 4'b1001, exp_word(d1, 0), 16};
    d2 = rand_digest();
    vecs[2] = '{d2, 4'b0110, exp_word(d2, 0), 16};

    reset = 1'b0; out_ready = 1'b0; out = '0; dout_ready = 1'b0; dout_ready8 = 1'b0;
    @(negedge clk);
    step(); step();
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_last", {31'd0, dout_last}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    reset = 1'b1;
    step();

    // Table-driven streams with varying backpressure.
    for (int v = 0; v < 3; v++) begin
      out = vecs[v].digest; out_ready = 1'b1; dout_ready = 1'b0;
      push(vecs[v].digest, 16, 1'b0);
      x0 = xfers;
      step();
      chk("lat1_valid", {31'd0, dout_valid}, 32'd1);
      chk("lat1_busy", {31'd0, busy}, 32'd1);
      chk("word0", dout, vecs[v].exp_w0);
      out_ready = 1'b0; out = rand_digest();  // falling level and new out are ignored
      drain(vecs[v].rdy, 200);
      chk("xfer_count", 32'(xfers - x0), 32'(vecs[v].exp_xfers));
      chk("done_valid", {31'd0, dout_valid}, 32'd0);
      chk("done_busy", {31'd0, busy}, 32'd0);
      step();
    end

    // Overrun: second rise at word 5.
    d1 = rand_digest(); d2 = rand_digest();
    out = d1; out_ready = 1'b1; dout_ready = 1'b1;
    push(d1, 16, 1'b0);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    out = d2; out_ready = 1'b1;
    step();
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    drain(4'b1111, 100);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    step(); step();
    chk("no_retrigger", {31'd0, dout_valid}, 32'd0);
    out_ready = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    chk("overrun_clr", {31'd0, overrun}, 32'd0);
    chk("overrun_rst_valid", {31'd0, dout_valid}, 32'd0);
    step();

    // Reset mid-SEND abandons the stream.
    out = d1; out_ready = 1'b1; dout_ready = 1'b1;
    push(d1, 16, 1'b0);
    step();
    out_ready = 1'b0;
    step(); step(); step();
    dout_ready = 1'b0; reset = 1'b0;
    sb.delete();
    step();
    reset = 1'b1;
    chk("midrst_valid", {31'd0, dout_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_last", {31'd0, dout_last}, 32'd0);
    chk("midrst_dout", dout, 32'd0);
    step();
    chk("midrst_idle", {31'd0, dout_valid}, 32'd0);

    // Rise coincident with the final transfer restarts with no gap.
    out = d1; out_ready = 1'b1; dout_ready = 1'b1;
    push(d1, 16, 1'b0);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("bnd_is_last", {31'd0, dout_last}, 32'd1);
    out = d2; out_ready = 1'b1;
    push(d2, 16, 1'b0);
    step();
    chk("bnd_valid", {31'd0, dout_valid}, 32'd1);
    chk("bnd_word0", dout, exp_word(d2, 0));
    chk("bnd_overrun", {31'd0, overrun}, 32'd0);
    out_ready = 1'b0;
    drain(4'b1111, 100);
    chk("bnd_done", {31'd0, busy}, 32'd0);

    // Truncated reader emits only the top 256 bits.
    reset = 1'b0; dout_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    out = inc; out_ready = 1'b1; dout_ready = 1'b1; dout_ready8 = 1'b1;
    push(inc, 16, 1'b0);
    push(inc, 8, 1'b1);
    x0 = xfers8;
    step();
    out_ready = 1'b0;
    drain(4'b1111, 100);
    chk("trunc_count", 32'(xfers8 - x0), 32'd8);
    chk("trunc_valid", {31'd0, dout_valid8}, 32'd0);
    chk("trunc_busy", {31'd0, busy8}, 32'd0);
    chk("trunc_overrun", {31'd0, overrun8}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
